decrypt_mem: RTL



---
 rtl/rc4_pkg.sv | 41 ++++
 rtl/decrypt_mem.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc4_pkg
// Description : Shared types and helpers for the RC4 key-search datapath.
//               Holds the decrypt-stage state encoding, the bounds of the
//               legal plaintext alphabet and the character legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

    // Decrypt-stage states; each message byte walks INC_I .. NEXT (14 states).
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_INC_I    = 4'd1,
        ST_READ_I   = 4'd2,
        ST_HOLD_I   = 4'd3,
        ST_SAVE_I   = 4'd4,
        ST_READ_J   = 4'd5,
        ST_HOLD_J   = 4'd6,
        ST_SAVE_J   = 4'd7,
        ST_WRITE_SI = 4'd8,
        ST_WRITE_SJ = 4'd9,
        ST_READ_F   = 4'd10,
        ST_HOLD_F   = 4'd11,
        ST_SAVE_F   = 4'd12,
        ST_WRITE_D  = 4'd13,
        ST_NEXT     = 4'd14,
        ST_DONE     = 4'd15
    } dec_state_t;

    // Legal plaintext alphabet: lower-case letters and space.
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    function automatic logic is_legal_char(input logic [7:0] ch);
        return ((ch >= CHAR_LO) && (ch <= CHAR_HI)) || (ch == CHAR_SPACE);
    endfunction

endpackage : rc4_pkg
`default_nettype wire

// File: rtl/decrypt_mem.sv
`default_nettype none
// ============================================================================
// Module      : decrypt_mem
// Description : RC4 keystream generation and message decryption. After the
//               key schedule has permuted S-RAM, generates MSG_LEN keystream
//               bytes, XORs each with the encrypted ROM and writes the result
//               to the decrypted RAM, flagging any illegal plaintext byte.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               start           - level, sampled in IDLE only
//               done            - high once the message is finished/aborted
//               key_bad         - sticky, some decrypted byte was illegal
//               s_address/s_data/s_wren/s_q         - S-RAM port
//               enc_address/enc_q                   - encrypted ROM port
//               dec_address/dec_data/dec_wren       - decrypted RAM port
//               All memory-port outputs are registered; memories are assumed
//               to have a one-cycle synchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
module decrypt_mem
    import rc4_pkg::*;
#(
    parameter int   MSG_LEN      = 32,
    parameter bit   ABORT_ON_BAD = 1'b1,
    localparam int  ADDR_W       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              key_bad,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [ADDR_W-1:0] enc_address,
    input  logic [7:0]        enc_q,
    output logic [ADDR_W-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wren
);

    localparam logic [ADDR_W-1:0] c_last_k = ADDR_W'(MSG_LEN - 1);

    dec_state_t        r_state;
    logic [7:0]        r_i;
    logic [7:0]        r_j;
    logic [7:0]        r_si;
    logic [7:0]        r_sj;
    logic [7:0]        r_f;
    logic [7:0]        r_enc_byte;
    logic [ADDR_W-1:0] r_k;

    // dec_data is registered in WRITE_D, so during NEXT it holds the byte
    // that is being written this cycle.
    logic w_bad;
    assign w_bad = !is_legal_char(dec_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_f         <= '0;
            r_enc_byte  <= '0;
            r_k         <= '0;
            done        <= 1'b0;
            key_bad     <= 1'b0;
            s_address   <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            enc_address <= '0;
            dec_address <= '0;
            dec_data    <= '0;
            dec_wren    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_INC_I;
                    end
                end
                ST_INC_I: begin
                    r_i     <= r_i + 8'd1;
                    r_state <= ST_READ_I;
                end
                ST_READ_I: begin
                    s_address <= r_i;
                    r_state   <= ST_HOLD_I;
                end
                ST_HOLD_I: r_state <= ST_SAVE_I;
                ST_SAVE_I: begin
                    r_si    <= s_q;
                    r_j     <= r_j + s_q;
                    r_state <= ST_READ_J;
                end
                ST_READ_J: begin
                    s_address <= r_j;
                    r_state   <= ST_HOLD_J;
                end
                ST_HOLD_J: r_state <= ST_SAVE_J;
                ST_SAVE_J: begin
                    r_sj    <= s_q;
                    r_state <= ST_WRITE_SI;
                end
                // Swap: S[i] <= sj first, then S[j] <= si, so when i == j the
                // second write leaves the original value in place.
                ST_WRITE_SI: begin
                    s_address <= r_i;
                    s_data    <= r_sj;
                    s_wren    <= 1'b1;
                    r_state   <= ST_WRITE_SJ;
                end
                ST_WRITE_SJ: begin
                    s_address <= r_j;
                    s_data    <= r_si;
                    s_wren    <= 1'b1;
                    r_state   <= ST_READ_F;
                end
                ST_READ_F: begin
                    s_wren      <= 1'b0;
                    s_address   <= r_si + r_sj;
                    enc_address <= r_k;
                    r_state     <= ST_HOLD_F;
                end
                ST_HOLD_F: r_state <= ST_SAVE_F;
                ST_SAVE_F: begin
                    r_f        <= s_q;
                    r_enc_byte <= enc_q;
                    r_state    <= ST_WRITE_D;
                end
                ST_WRITE_D: begin
                    dec_wren    <= 1'b1;
                    dec_address <= r_k;
                    dec_data    <= r_f ^ r_enc_byte;
                    r_state     <= ST_NEXT;
                end
                ST_NEXT: begin
                    dec_wren <= 1'b0;
                    if (w_bad) begin
                        key_bad <= 1'b1;
                    end
                    if ((r_k == c_last_k) || (ABORT_ON_BAD && w_bad)) begin
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_k     <= r_k + ADDR_W'(1);
                        r_state <= ST_INC_I;
                    end
                end
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : decrypt_mem
`default_nettype wire
